wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Timing stage directly upstream of the automatic washing machine controller.
- Produces that controller's cycle_timeout and spin_timeout inputs.
- Counts the wash-agitation and spin durations in prescaled time units while the controller requests each phase.
- Supports pause and abort, and exposes remaining time for display.

Parameters:
- PRESCALE, 100, clk cycles per time unit; must be >= 1.
- CNT_W, 16, width of the unit counter and of the remaining output.
- CYCLE_UNITS, 600, wash/agitate duration in units; must be 1 .. 2^CNT_W-1.
- SPIN_UNITS, 300, spin duration in units; must be 1 .. 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cycle_en  input  1  controller requests wash timing; driven from the controller's motor_on.
- spin_en  input  1  controller requests spin timing; high while the controller is in spin.
- pause  input  1  freeze timing, e.g. a door or imbalance hold.
- cycle_timeout  output  1  wash duration elapsed; level output.
- spin_timeout  output  1  spin duration elapsed; level output.
- busy  output  1  a phase is currently being timed.
- remaining  output  CNT_W  units left in the active phase; 0 when idle.

Behaviour:
- All outputs are registered. Reset drives state to IDLE and all counters and outputs to 0.
- Reset is honoured mid-phase with no residual timeout.
- States: IDLE, RUN_CYCLE, RUN_SPIN, EXPIRED. A phase register records which phase expired.
- IDLE:
  - cycle_en=1 -> RUN_CYCLE; load counter=CYCLE_UNITS, prescaler=0, busy=1.
  - else spin_en=1 -> RUN_SPIN; load counter=SPIN_UNITS.
  - cycle_en has priority when both are high.
- RUN_x, each edge:
  - If the phase's enable is 0: abort to IDLE, clear counter and prescaler, busy=0, no timeout.
  - Else if pause=1: hold prescaler and counter.
  - Else increment prescaler. At PRESCALE-1 the prescaler wraps to 0 and the counter decrements.
  - When the decrement reaches 0: go to EXPIRED and set the matching timeout=1 at the same edge. busy=0.
- Latency: enable sampled high at edge k with no pause -> timeout high after edge k + UNITS*PRESCALE.
- Each pause cycle adds exactly one cycle to that latency.
- EXPIRED:
  - Timeout stays high while the phase's enable stays high. The controller samples it combinationally and leaves the state one edge later.
  - When that enable drops -> IDLE; timeout cleared at that edge.
  - The other enable rising while in EXPIRED is ignored until IDLE is reached, so a new phase starts one edge after IDLE is re-entered.
- Enable dropped and re-raised:
  - Always restarts a full duration; there is no resume.
  - Re-raise in the same cycle as the abort edge is not possible, since the drop is sampled first.
- remaining reflects the counter value during RUN states. It is held during pause and is 0 in IDLE and EXPIRED.
- cycle_timeout and spin_timeout are never high simultaneously.
- Prescaler width is clog2(PRESCALE), minimum 1 bit. PRESCALE=1 means the counter decrements every unpaused cycle.

Decomposition:
- Shared package wash_pkg holds:
  - the timer state typedef (IDLE/RUN_CYCLE/RUN_SPIN/EXPIRED);
  - the default PRESCALE/CYCLE_UNITS/SPIN_UNITS constants, shared with the controller bench.
- One natural sub-module: wash_tick_gen. It is the prescaler, with inputs clear, enable (= running & ~pause) and output tick (1 cycle at wrap).
- The top level holds the FSM and the unit counter.

Test Plan (PRESCALE=4, CYCLE_UNITS=3, SPIN_UNITS=2, CNT_W=8):
- Wash timing: reset, then cycle_en=1 from edge 0 -> remaining 3,2,1 stepping every 4 cycles. cycle_timeout=1 after edge 12 and held until cycle_en=0, cleared the next edge. spin_timeout stays 0 throughout.
- Spin timing: spin_en=1 from edge 0 -> spin_timeout=1 after edge 8. busy=1 for edges 0-7.
- Pause: cycle_en=1, pause=1 for 5 cycles starting at edge 3 -> cycle_timeout after edge 17. remaining is frozen during the pause.
- Abort/restart: cycle_en dropped at edge 6 -> IDLE, remaining=0, no timeout. Re-raised at edge 8 -> timeout after edge 20.
- Priority and collision: cycle_en and spin_en both raised at edge 0 -> RUN_CYCLE, cycle_timeout at edge 12. After cycle_en drops -> IDLE, then RUN_SPIN one edge later; spin_timeout 8 edges after that.
- Reset mid-run: reset asserted asynchronously at cycle 7 between edges -> all outputs 0 immediately. After release with cycle_en held, a full 12-cycle count restarts.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine timing stage and its controller bench.
// Holds the timer state encoding, phase tags and default durations.
package wash_pkg;

  localparam int DEF_PRESCALE    = 100;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_CYCLE_UNITS = 600;
  localparam int DEF_SPIN_UNITS  = 300;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_CYCLE = 2'd1,
    RUN_SPIN  = 2'd2,
    EXPIRED   = 2'd3
  } timer_state_t;

  typedef enum logic {
    PH_CYCLE = 1'b0,
    PH_SPIN  = 1'b1
  } phase_t;

  // A prescaler of one cycle still needs a 1-bit register to stay legal.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Prescaler for the phase timer: emits a one-cycle tick each time it wraps.
// clear has priority over enable and returns the count to zero.
module wash_tick_gen
  import wash_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PS_W = presc_width(PRESCALE);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;
  logic            wrap;

  assign wrap = (count == LAST);
  assign tick = enable & ~clear & wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + PS_W'(1);
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Times the wash-agitation and spin phases for the washing-machine controller.
// Timeouts are level outputs held until the requesting enable drops.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_UNITS = DEF_CYCLE_UNITS,
  parameter int SPIN_UNITS  = DEF_SPIN_UNITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_en,
  input  logic             spin_en,
  input  logic             pause,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  timer_state_t     state;
  phase_t           phase;
  logic [CNT_W-1:0] counter;
  logic             running;
  logic             phase_en;
  logic             tick_clear;
  logic             tick_enable;
  logic             tick;

  // counter is only non-zero in RUN states, so it doubles as the display value.
  assign remaining = counter;

  always_comb begin
    running     = ((state == RUN_CYCLE) && cycle_en) ||
                  ((state == RUN_SPIN)  && spin_en);
    phase_en    = (phase == PH_CYCLE) ? cycle_en : spin_en;
    tick_clear  = ~running;
    tick_enable = running & ~pause;
  end

  wash_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= PH_CYCLE;
      counter       <= '0;
      busy          <= 1'b0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cycle_en) begin
            state   <= RUN_CYCLE;
            phase   <= PH_CYCLE;
            counter <= CNT_W'(CYCLE_UNITS);
            busy    <= 1'b1;
          end else if (spin_en) begin
            state   <= RUN_SPIN;
            phase   <= PH_SPIN;
            counter <= CNT_W'(SPIN_UNITS);
            busy    <= 1'b1;
          end
        end
        RUN_CYCLE, RUN_SPIN: begin
          if (!running) begin
            // Abort: no resume, the next request reloads a full duration.
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
          end else if (tick) begin
            if (counter == CNT_W'(1)) begin
              state         <= EXPIRED;
              counter       <= '0;
              busy          <= 1'b0;
              cycle_timeout <= (phase == PH_CYCLE);
              spin_timeout  <= (phase == PH_SPIN);
            end else begin
              counter <= counter - CNT_W'(1);
            end
          end
        end
        EXPIRED: begin
          // The other enable is ignored here; it is picked up from IDLE.
          if (!phase_en) begin
            state         <= IDLE;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
